// File: rtl/mem_sequencer_if.sv
// Avalon-style single memory port between mem_sequencer (master) and the bus (slave).
// Carries address, strobes, byte enables and write data out, and waitrequest back.
interface mem_sequencer_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest
    );
endinterface

// File: rtl/mem_sequencer.sv
// Multi-cycle CPU controller: FETCH/EXEC1/EXEC2/HALTED sequencing and memory port arbitration.
// Optional performance counters are built only when PERF_COUNTER_EN is defined.
//
//  state  | meaning
//  FETCH  | instruction read on the bus at pc_i
//  EXEC1  | read data valid; latch data request, decide halt
//  EXEC2  | optional load/store; waits on waitrequest_i and stall_i
//  HALTED | absorbing until reset; bus idle, active_o low
module mem_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset_n_i,
    mem_sequencer_if.master      bus,
    input  logic [31:0]          pc_i,
    input  logic                 data_req_i,
    input  logic                 data_we_i,
    input  logic [31:0]          data_addr_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_wdata_i,
    input  logic                 halt_req_i,
    input  logic                 stall_i,
    output logic [1:0]           state_o,
    output logic                 active_o,
    output logic                 bus_err_o,
    output logic [31:0]          instr_count_o,
    output logic [31:0]          wait_count_o
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC1  = 2'd1,
        EXEC2  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        done_q;
    logic [31:0] wait_q;
    logic        bus_err_q;

    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        strobe;
    logic        stalled;
    logic        accepted;
    logic        data_pending;
    logic [31:0] wait_nxt;
    logic        timeout_hit;

    // Strobes come straight from the registered state so they are forced low in the reset cycle.
    always_comb begin
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 32'h0;
        be    = 4'h0;
        wdata = 32'h0;
        data_pending = (state_q == EXEC2) && req_q && !done_q;
        if (reset_n_i) begin
            case (state_q)
                FETCH: begin
                    rd   = 1'b1;
                    addr = pc_i;
                    be   = 4'hF;
                end
                EXEC2: begin
                    if (data_pending) begin
                        rd    = ~we_q;
                        wr    = we_q;
                        addr  = addr_q;
                        be    = be_q;
                        wdata = we_q ? wdata_q : 32'h0;
                    end
                end
                default: ;
            endcase
        end
        strobe      = rd | wr;
        stalled     = strobe & bus.waitrequest;
        accepted    = strobe & ~bus.waitrequest;
        wait_nxt    = wait_q + 32'd1;
        timeout_hit = (TIMEOUT_CYCLES != 0) && stalled && (wait_nxt >= 32'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q   <= FETCH;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            done_q    <= 1'b0;
            wait_q    <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            if (!stalled)
                wait_q <= 32'h0;
            else if (wait_q != 32'hFFFF_FFFF)
                wait_q <= wait_nxt;

            case (state_q)
                FETCH: begin
                    if (timeout_hit) begin
                        state_q   <= HALTED;
                        bus_err_q <= 1'b1;
                    end else if (accepted) begin
                        state_q <= EXEC1;
                    end
                end
                EXEC1: begin
                    req_q   <= data_req_i;
                    we_q    <= data_we_i;
                    addr_q  <= data_addr_i;
                    be_q    <= data_be_i;
                    wdata_q <= data_wdata_i;
                    done_q  <= 1'b0;
                    state_q <= halt_req_i ? HALTED : EXEC2;
                end
                EXEC2: begin
                    if (accepted)
                        done_q <= 1'b1;
                    if (timeout_hit) begin
                        state_q   <= HALTED;
                        bus_err_q <= 1'b1;
                    end else if ((!data_pending || !bus.waitrequest) && !stall_i) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= HALTED;
            endcase
        end
    end

    assign bus.address    = addr;
    assign bus.read       = rd;
    assign bus.write      = wr;
    assign bus.byteenable = be;
    assign bus.writedata  = wdata;
    assign state_o        = state_q;
    assign active_o       = reset_n_i && (state_q != HALTED);
    assign bus_err_o      = bus_err_q;

`ifdef PERF_COUNTER_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            instr_cnt_q <= 32'h0;
            wait_cnt_q  <= 32'h0;
        end else begin
            if ((state_q == FETCH) && accepted && (instr_cnt_q != 32'hFFFF_FFFF))
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if (stalled && (wait_cnt_q != 32'hFFFF_FFFF))
                wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign instr_count_o = instr_cnt_q;
    assign wait_count_o  = wait_cnt_q;
`else
    assign instr_count_o = 32'h0;
    assign wait_count_o  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed, table-driven bench for mem_sequencer, plus hand sequences for
// waitrequest stalls, bus timeout and reset in the middle of a transfer.
module tb_mem_sequencer;

    localparam logic [1:0] S_F = 2'd0;
    localparam logic [1:0] S_1 = 2'd1;
    localparam logic [1:0] S_2 = 2'd2;
    localparam logic [1:0] S_H = 2'd3;

    logic        clk = 1'b0;
    logic        rst1, rst2;
    logic [31:0] pc;
    logic        dreq, dwe, halt, stall;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbe;

    logic [1:0]  state1, state2;
    logic        act1, act2, err1, err2;
    logic [31:0] icnt1, wcnt1, icnt2, wcnt2;

    int n_vec = 0;
    int n_err = 0;

    mem_sequencer_if bus1();
    mem_sequencer_if bus2();

    always #5 clk = ~clk;

    mem_sequencer #(.TIMEOUT_CYCLES(0)) dut (
        .clk(clk), .reset_n_i(rst1), .bus(bus1), .pc_i(pc),
        .data_req_i(dreq), .data_we_i(dwe), .data_addr_i(daddr), .data_be_i(dbe),
        .data_wdata_i(dwdata), .halt_req_i(halt), .stall_i(stall),
        .state_o(state1), .active_o(act1), .bus_err_o(err1),
        .instr_count_o(icnt1), .wait_count_o(wcnt1)
    );

    mem_sequencer #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset_n_i(rst2), .bus(bus2), .pc_i(pc),
        .data_req_i(dreq), .data_we_i(dwe), .data_addr_i(daddr), .data_be_i(dbe),
        .data_wdata_i(dwdata), .halt_req_i(halt), .stall_i(stall),
        .state_o(state2), .active_o(act2), .bus_err_o(err2),
        .instr_count_o(icnt2), .wait_count_o(wcnt2)
    );

    typedef struct {
        logic        rst_n;
        logic        wreq;
        logic [31:0] pc;
        logic        dreq;
        logic        we;
        logic [31:0] daddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        halt;
        logic        stall;
        logic [1:0]  e_state;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_act;
    } vec_t;

    vec_t vt[18];

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_wc, exp_ic;

        //        rst wrq pc            drq we daddr        be    wdata         hlt stl | st  rd wr addr          be    wd            act
        vt[0]  = '{0, 0, 32'hBFC00000, 0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_F, 0, 0, 32'h0,        4'h0, 32'h0,        0};
        vt[1]  = '{1, 0, 32'hBFC00000, 0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_F, 1, 0, 32'hBFC00000, 4'hF, 32'h0,        1};
        vt[2]  = '{1, 0, 32'h0,        1, 1, 32'h1000,    4'h3, 32'hDEADBEEF, 0, 0,  S_1, 0, 0, 32'h0,        4'h0, 32'h0,        1};
        vt[3]  = '{1, 1, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_2, 0, 1, 32'h1000,     4'h3, 32'hDEADBEEF, 1};
        vt[4]  = '{1, 0, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_2, 0, 1, 32'h1000,     4'h3, 32'hDEADBEEF, 1};
        vt[5]  = '{1, 0, 32'h100,      0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_F, 1, 0, 32'h100,      4'hF, 32'h0,        1};
        vt[6]  = '{1, 0, 32'h0,        1, 0, 32'h2000,    4'hF, 32'h12345678, 0, 0,  S_1, 0, 0, 32'h0,        4'h0, 32'h0,        1};
        vt[7]  = '{1, 0, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 1,  S_2, 1, 0, 32'h2000,     4'hF, 32'h0,        1};
        vt[8]  = '{1, 0, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 1,  S_2, 0, 0, 32'h0,        4'h0, 32'h0,        1};
        vt[9]  = '{1, 1, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 1,  S_2, 0, 0, 32'h0,        4'h0, 32'h0,        1};
        vt[10] = '{1, 0, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_2, 0, 0, 32'h0,        4'h0, 32'h0,        1};
        vt[11] = '{1, 0, 32'h104,      0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_F, 1, 0, 32'h104,      4'hF, 32'h0,        1};
        vt[12] = '{1, 0, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_1, 0, 0, 32'h0,        4'h0, 32'h0,        1};
        vt[13] = '{1, 1, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_2, 0, 0, 32'h0,        4'h0, 32'h0,        1};
        vt[14] = '{1, 0, 32'h108,      0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_F, 1, 0, 32'h108,      4'hF, 32'h0,        1};
        vt[15] = '{1, 0, 32'h0,        1, 1, 32'h3000,    4'hF, 32'hAAAA5555, 1, 0,  S_1, 0, 0, 32'h0,        4'h0, 32'h0,        1};
        vt[16] = '{1, 0, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_H, 0, 0, 32'h0,        4'h0, 32'h0,        0};
        vt[17] = '{1, 1, 32'h0,        0, 0, 32'h0,       4'h0, 32'h0,        0, 0,  S_H, 0, 0, 32'h0,        4'h0, 32'h0,        0};

        rst1 = 1'b0; rst2 = 1'b0;
        pc = 32'hBFC00000; dreq = 0; dwe = 0; daddr = 0; dbe = 0; dwdata = 0;
        halt = 0; stall = 0;
        bus1.waitrequest = 1'b0;
        bus2.waitrequest = 1'b0;
        tick;
        tick;

        for (int i = 0; i < 18; i++) begin
            rst1 = vt[i].rst_n; bus1.waitrequest = vt[i].wreq; pc = vt[i].pc;
            dreq = vt[i].dreq; dwe = vt[i].we; daddr = vt[i].daddr; dbe = vt[i].be;
            dwdata = vt[i].wdata; halt = vt[i].halt; stall = vt[i].stall;
            #1;
            chk($sformatf("v%0d.state", i), 32'(state1), 32'(vt[i].e_state));
            chk($sformatf("v%0d.read", i), 32'(bus1.read), 32'(vt[i].e_rd));
            chk($sformatf("v%0d.write", i), 32'(bus1.write), 32'(vt[i].e_wr));
            chk($sformatf("v%0d.address", i), bus1.address, vt[i].e_addr);
            chk($sformatf("v%0d.byteenable", i), 32'(bus1.byteenable), 32'(vt[i].e_be));
            chk($sformatf("v%0d.writedata", i), bus1.writedata, vt[i].e_wd);
            chk($sformatf("v%0d.active", i), 32'(act1), 32'(vt[i].e_act));
            tick;
        end

        // Fetch held off by waitrequest for three cycles, then accepted.
        rst1 = 1'b0; bus1.waitrequest = 1'b0; halt = 0; dreq = 0; stall = 0;
        tick;
        rst1 = 1'b1; pc = 32'h200; bus1.waitrequest = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("wr%0d.state", c), 32'(state1), 32'(S_F));
            chk($sformatf("wr%0d.read", c), 32'(bus1.read), 32'd1);
            chk($sformatf("wr%0d.address", c), bus1.address, 32'h200);
            tick;
        end
        bus1.waitrequest = 1'b0;
        tick;
`ifdef PERF_COUNTER_EN
        exp_wc = 32'd3; exp_ic = 32'd1;
`else
        exp_wc = 32'd0; exp_ic = 32'd0;
`endif
        chk("wr.exec1", 32'(state1), 32'(S_1));
        chk("wr.wait_count", wcnt1, exp_wc);
        chk("wr.instr_count", icnt1, exp_ic);
        chk("wr.bus_err", 32'(err1), 32'd0);

        // Load pending under waitrequest, then reset lands mid-EXEC2.
        dreq = 1; dwe = 0; daddr = 32'h4000; dbe = 4'hF;
        tick;
        dreq = 0;
        bus1.waitrequest = 1'b1;
        #1;
        chk("mid.read", 32'(bus1.read), 32'd1);
        chk("mid.address", bus1.address, 32'h4000);
        rst1 = 1'b0;
        #1;
        chk("mid.read_rst", 32'(bus1.read), 32'd0);
        chk("mid.write_rst", 32'(bus1.write), 32'd0);
        chk("mid.active_rst", 32'(act1), 32'd0);
        tick;
        chk("mid.state_rst", 32'(state1), 32'(S_F));
        chk("mid.read_held", 32'(bus1.read), 32'd0);
        rst1 = 1'b1; bus1.waitrequest = 1'b0; pc = 32'h300;
        #1;
        chk("mid.state_rel", 32'(state1), 32'(S_F));
        chk("mid.read_rel", 32'(bus1.read), 32'd1);
        chk("mid.address_rel", bus1.address, 32'h300);

        // Timeout instance: fetch stuck in waitrequest halts after four stall cycles.
        tick;
        rst2 = 1'b1; bus2.waitrequest = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk($sformatf("to%0d.state", c), 32'(state2), 32'(S_F));
            chk($sformatf("to%0d.bus_err", c), 32'(err2), 32'd0);
        end
        tick;
        chk("to.halted", 32'(state2), 32'(S_H));
        chk("to.bus_err", 32'(err2), 32'd1);
        chk("to.active", 32'(act2), 32'd0);
        chk("to.read", 32'(bus2.read), 32'd0);
        tick;
        chk("to.err_sticky", 32'(err2), 32'd1);
        rst2 = 1'b0;
        tick;
        chk("to.reset_state", 32'(state2), 32'(S_F));
        chk("to.reset_err", 32'(err2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
